piu_pplist_writer: RTL and testbench

Builds the per-patch Pauli-product lists that drive the PIU dynamic boundary decoder. It accepts a stream of (slot, patch index, Pauli product) writes from the PIU instruction path and assembles them in per-slot shadow lists. Each assembled list is checked against the other slot and committed to `pchpp_list_reg0` or `pchpp_list_reg1`, where it is held until explicitly released. The decoder bitwise-ORs both registers per patch, so this block guarantees that no patch is non-identity in both committed slots.

---
 rtl/piu_pplist_writer.sv | 135 +++++++++++++
 tb/tb_piu_pplist_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/piu_pplist_writer.sv
// Assembles per-slot Pauli-product lists and commits them to the decoder
// registers, guaranteeing no patch is non-identity in both committed slots.
module piu_pplist_writer #(
  parameter int NUM_PCH    = 20,
  parameter int PCHADDR_BW = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_slot,
  input  logic [PCHADDR_BW-1:0]  in_pchidx,
  input  logic [1:0]             in_pp,
  input  logic                   in_last,
  input  logic                   rel_valid,
  input  logic                   rel_slot,
  output logic [NUM_PCH*2-1:0]   pchpp_list_reg0,
  output logic [NUM_PCH*2-1:0]   pchpp_list_reg1,
  output logic [1:0]             slot_committed,
  output logic                   err_conflict,
  output logic                   err_range
);

  localparam int W = NUM_PCH * 2;
  localparam logic [PCHADDR_BW:0] PCH_LIM =
    (PCHADDR_BW+1)'(NUM_PCH);

  typedef enum logic [1:0] {
    IDLE,
    BUILD,
    CHECK,
    COMMIT
  } st_t;

  st_t          st [2];
  logic [1:0]   last_q;
  logic [W-1:0] shad [2];
  logic [W-1:0] outr [2];
  logic         err_c_q;
  logic         err_r_q;

  logic [1:0]   open;
  logic [1:0]   acc;
  logic [1:0]   go;
  logic [1:0]   conf;
  logic         in_rng;

  // last_q holds the slot closed for one cycle after its final write,
  // so the check always sees a settled shadow list.
  always_comb begin
    open = '0;
    acc  = '0;
    for (int s = 0; s < 2; s++) begin
      open[s] = (st[s] == IDLE || st[s] == BUILD) && !last_q[s];
      acc[s]  = in_valid && open[s] && (in_slot == 1'(s));
    end
  end

  assign in_ready = open[in_slot];
  assign in_rng   = {1'b0, in_pchidx} < PCH_LIM;

  // Slot 0 wins when both slots are checking in the same cycle.
  assign go[0] = (st[0] == CHECK);
  assign go[1] = (st[1] == CHECK) && (st[0] != CHECK);

  always_comb begin
    conf = '0;
    for (int i = 0; i < NUM_PCH; i++) begin
      if ((|shad[0][2*i +: 2]) && (|outr[1][2*i +: 2]))
        conf[0] = 1'b1;
      if ((|shad[1][2*i +: 2]) && (|outr[0][2*i +: 2]))
        conf[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        st[s]   <= IDLE;
        shad[s] <= '0;
        outr[s] <= '0;
      end
      last_q  <= '0;
      err_c_q <= 1'b0;
      err_r_q <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (acc[s]) begin
          for (int i = 0; i < NUM_PCH; i++) begin
            if (in_rng && in_pchidx == PCHADDR_BW'(i))
              shad[s][2*i +: 2] <= in_pp;
          end
          last_q[s] <= in_last;
          if (!in_last)
            st[s] <= BUILD;
        end
        if (last_q[s]) begin
          last_q[s] <= 1'b0;
          st[s]     <= CHECK;
        end
        case (st[s])
          CHECK: begin
            if (go[s]) begin
              shad[s] <= '0;
              if (conf[s]) begin
                err_c_q <= 1'b1;
                st[s]   <= IDLE;
              end else begin
                outr[s] <= shad[s];
                st[s]   <= COMMIT;
              end
            end
          end
          COMMIT: begin
            if (rel_valid && rel_slot == 1'(s)) begin
              outr[s] <= '0;
              st[s]   <= IDLE;
            end
          end
          default: ;
        endcase
      end
      if ((|acc) && !in_rng)
        err_r_q <= 1'b1;
    end
  end

  assign pchpp_list_reg0   = outr[0];
  assign pchpp_list_reg1   = outr[1];
  assign slot_committed[0] = (st[0] == COMMIT);
  assign slot_committed[1] = (st[1] == COMMIT);
  assign err_conflict      = err_c_q;
  assign err_range         = err_r_q;

endmodule

// File: tb/tb_piu_pplist_writer.sv
// Randomized and directed bench for piu_pplist_writer against a
// list-level reference model.
module tb_piu_pplist_writer;

  localparam int N  = 20;
  localparam int BW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_slot;
  logic [BW-1:0] in_pchidx;
  logic [1:0]    in_pp;
  logic          in_last;
  logic          rel_valid;
  logic          rel_slot;
  logic [2*N-1:0] r0;
  logic [2*N-1:0] r1;
  logic [1:0]    sc;
  logic          ec;
  logic          er;

  piu_pplist_writer #(
    .NUM_PCH(N),
    .PCHADDR_BW(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_slot(in_slot),
    .in_pchidx(in_pchidx),
    .in_pp(in_pp),
    .in_last(in_last),
    .rel_valid(rel_valid),
    .rel_slot(rel_slot),
    .pchpp_list_reg0(r0),
    .pchpp_list_reg1(r1),
    .slot_committed(sc),
    .err_conflict(ec),
    .err_range(er)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: per slot a phase (0 open, 1 list closed, 2 checking,
  // 3 held) plus plain patch arrays.
  int         ph [2];
  logic [1:0] sh [2][N];
  logic [1:0] ov [2][N];
  bit         m_ec;
  bit         m_er;

  function automatic logic [2*N-1:0] pack(int s);
    logic [2*N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[2*i +: 2] = ov[s][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      ph[s] = 0;
      for (int i = 0; i < N; i++) begin
        sh[s][i] = 2'b00;
        ov[s][i] = 2'b00;
      end
    end
    m_ec = 0;
    m_er = 0;
  endtask

  task automatic model_step();
    int  nph [2];
    bit  cf [2];
    bit  gs [2];
    int  sl;
    int  idx;
    if (rst) begin
      model_reset();
      return;
    end
    for (int s = 0; s < 2; s++) begin
      nph[s] = ph[s];
      cf[s]  = 0;
      for (int i = 0; i < N; i++)
        if (sh[s][i] != 0 && ov[1-s][i] != 0) cf[s] = 1;
    end
    gs[0] = (ph[0] == 2);
    gs[1] = (ph[1] == 2) && (ph[0] != 2);
    for (int s = 0; s < 2; s++) begin
      if (rel_valid && int'(rel_slot) == s && ph[s] == 3) begin
        for (int i = 0; i < N; i++) ov[s][i] = 2'b00;
        nph[s] = 0;
      end
      if (gs[s]) begin
        if (cf[s]) begin
          m_ec   = 1;
          nph[s] = 0;
        end else begin
          for (int i = 0; i < N; i++) ov[s][i] = sh[s][i];
          nph[s] = 3;
        end
        for (int i = 0; i < N; i++) sh[s][i] = 2'b00;
      end
      if (ph[s] == 1) nph[s] = 2;
    end
    sl  = int'(in_slot);
    idx = int'(in_pchidx);
    if (in_valid && ph[sl] == 0) begin
      if (idx < N) sh[sl][idx] = in_pp;
      else m_er = 1;
      if (in_last) nph[sl] = 1;
    end
    ph[0] = nph[0];
    ph[1] = nph[1];
  endtask

  task automatic cyc(bit v, bit sl, int idx, logic [1:0] pp,
                     bit last, bit rv, bit rs, bit r);
    in_valid  = v;
    in_slot   = sl;
    in_pchidx = BW'(idx);
    in_pp     = pp;
    in_last   = last;
    rel_valid = rv;
    rel_slot  = rs;
    rst       = r;
    #1;
    chk("in_ready", in_ready, ph[sl] == 0);
    @(posedge clk);
    model_step();
    #1;
    chk("reg0", r0, pack(0));
    chk("reg1", r1, pack(1));
    chk("slot_committed", sc, {ph[1] == 3, ph[0] == 3});
    chk("err_conflict", ec, m_ec);
    chk("err_range", er, m_er);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    cyc(0, 0, 0, 2'b00, 0, 0, 0, 1);
    chk("rst_reg0", r0, 0);
    chk("rst_sc", sc, 0);
    chk("rst_ready", in_ready, 1);

    cyc(1, 0, 2, 2'b10, 0, 0, 0, 0);
    cyc(1, 0, 5, 2'b01, 0, 0, 0, 0);
    cyc(1, 0, 7, 2'b11, 1, 0, 0, 0);
    idle();
    chk("tp1_latency", r0, 0);
    idle();
    chk("tp1_reg0", r0, 40'hC420);
    chk("tp1_sc", sc, 2'b01);

    cyc(1, 1, 5, 2'b10, 1, 0, 0, 0);
    idle();
    idle();
    chk("tp2_err", ec, 1);
    chk("tp2_reg1", r1, 0);
    chk("tp2_sc", sc, 2'b01);
    cyc(1, 1, 6, 2'b10, 1, 0, 0, 0);
    idle();
    idle();
    chk("tp2_sc11", sc, 2'b11);
    chk("tp2_reg1b", r1, 40'h2000);

    in_valid = 1;
    in_slot  = 0;
    #1;
    chk("tp3_ready0", in_ready, 0);
    cyc(0, 0, 0, 2'b00, 0, 1, 0, 0);
    chk("tp3_ready1", in_ready, 1);
    chk("tp3_reg0", r0, 0);

    cyc(0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc(1, 0, 3, 2'b01, 1, 0, 0, 0);
    cyc(1, 1, 3, 2'b10, 1, 0, 0, 0);
    idle();
    chk("tp4_reg0", r0, 40'h40);
    chk("tp4_noerr", ec, 0);
    idle();
    chk("tp4_err", ec, 1);
    chk("tp4_reg1", r1, 0);
    chk("tp4_sc", sc, 2'b01);

    cyc(1, 1, 25, 2'b01, 0, 0, 0, 0);
    chk("tp5_range", er, 1);
    chk("tp5_reg0", r0, 40'h40);
    cyc(1, 1, 4, 2'b10, 0, 0, 0, 0);
    cyc(0, 0, 0, 2'b00, 0, 0, 0, 1);
    chk("tp5_rst_reg0", r0, 0);
    chk("tp5_rst_sc", sc, 0);
    chk("tp5_rst_er", er, 0);
    chk("tp5_rst_ec", ec, 0);

    for (int k = 0; k < 3000; k++) begin
      automatic int idx = ($urandom_range(0, 9) == 0) ?
        $urandom_range(20, 31) : $urandom_range(0, 19);
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), idx,
          2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 399) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
